// File: rtl/simul_saxi_gp_rd_if.sv
// rtl/simul_saxi_gp_rd_if.sv - AR/R bus and simulation-memory port bundle for the S_AXI_GP read model
interface simul_saxi_gp_rd_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [5:0]  arid;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arlen;
  logic [1:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arqos;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [5:0]  rid;
  logic        rlast;
  logic [1:0]  rresp;
  logic [31:0] sim_rd_address;
  logic [5:0]  sim_rid;
  logic        sim_rd_valid;
  logic        sim_rd_ready;
  logic [31:0] sim_rd_data;
  logic [1:0]  sim_rd_size;
  logic [3:0]  sim_rd_qos;

  modport slave (
    input  araddr, arvalid, arid, arlock, arcache, arprot, arlen, arsize, arburst, arqos,
    input  rready, sim_rd_ready, sim_rd_data,
    output arready, rdata, rvalid, rid, rlast, rresp,
    output sim_rd_address, sim_rid, sim_rd_valid, sim_rd_size, sim_rd_qos
  );

  modport master (
    output araddr, arvalid, arid, arlock, arcache, arprot, arlen, arsize, arburst, arqos,
    output rready, sim_rd_ready, sim_rd_data,
    input  arready, rdata, rvalid, rid, rlast, rresp,
    input  sim_rd_address, sim_rid, sim_rd_valid, sim_rd_size, sim_rd_qos
  );
endinterface

// File: rtl/simul_saxi_gp_rd.sv
// rtl/simul_saxi_gp_rd.sv - S_AXI_GP read channel model: AR queue, burst-to-beat expansion, R queue
// Optional attribute checking on AR handshakes: define SAXI_GP_RD_ATTR_CHECK_EN.
module simul_saxi_gp_rd #(
  parameter int AR_FIFO_DEPTH = 3,
  parameter int R_FIFO_DEPTH  = 3
) (
  input logic                aclk,
  input logic                aresetn,
  simul_saxi_gp_rd_if.slave  bus
);
  localparam int AR_FIFO_NUM = 1 << AR_FIFO_DEPTH;
  localparam int R_FIFO_NUM  = 1 << R_FIFO_DEPTH;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  id;
    logic [3:0]  len;
    logic [1:0]  size;
    logic [1:0]  burst;
    logic [3:0]  qos;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  id;
    logic        last;
    logic [1:0]  resp;
  } r_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  ar_t                  ar_mem [AR_FIFO_NUM];
  logic [AR_FIFO_DEPTH-1:0] ar_wr_q, ar_rd_q;
  logic [AR_FIFO_DEPTH:0]   ar_cnt_q;
  r_t                   r_mem [R_FIFO_NUM];
  logic [R_FIFO_DEPTH-1:0]  r_wr_q, r_rd_q;
  logic [R_FIFO_DEPTH:0]    r_cnt_q;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [5:0]  id_q, id_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  qos_q, qos_d;
  logic [3:0]  beats_q, beats_d;

  logic ar_push, ar_pop, ar_nonempty, r_full, r_push, r_pop;
  logic sim_valid, beat, last_beat;
  ar_t  ar_in, ar_head;
  r_t   r_head;

  // Count MSB is set only at exactly full capacity.
  assign ar_nonempty = (ar_cnt_q != '0);
  assign r_full      = r_cnt_q[R_FIFO_DEPTH];
  assign bus.arready = !ar_cnt_q[AR_FIFO_DEPTH];
  assign ar_push     = bus.arvalid && bus.arready;
  assign ar_in       = '{addr: bus.araddr, id: bus.arid, len: bus.arlen, size: bus.arsize,
                         burst: bus.arburst, qos: bus.arqos};
  assign ar_head     = ar_mem[ar_rd_q];

  always_ff @(posedge aclk) begin
    if (ar_push) ar_mem[ar_wr_q] <= ar_in;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_wr_q  <= '0;
      ar_rd_q  <= '0;
      ar_cnt_q <= '0;
    end else begin
      if (ar_push) ar_wr_q <= ar_wr_q + 1'b1;
      if (ar_pop)  ar_rd_q <= ar_rd_q + 1'b1;
      case ({ar_push, ar_pop})
        2'b10:   ar_cnt_q <= ar_cnt_q + 1'b1;
        2'b01:   ar_cnt_q <= ar_cnt_q - 1'b1;
        default: ar_cnt_q <= ar_cnt_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ar_nonempty) state_d = S_BURST;
      S_BURST: if (last_beat && !ar_nonempty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The next burst is popped on the final beat so bursts run without a bubble.
  always_comb begin
    sim_valid = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    ar_pop    = 1'b0;
    case (state_q)
      S_IDLE: ar_pop = ar_nonempty;
      S_BURST: begin
        sim_valid = !r_full;
        beat      = sim_valid && bus.sim_rd_ready;
        last_beat = beat && (beats_q == 4'd0);
        ar_pop    = last_beat && ar_nonempty;
      end
      default: ;
    endcase
  end

  logic [11:0] step, low_mask, idx, wrap_idx, wrap_off, next_off;
  always_comb begin
    step     = 12'd1 << size_q;
    low_mask = step - 12'd1;
    idx      = addr_q[11:0] >> size_q;
    wrap_idx = (idx & ~{8'd0, len_q}) | ((idx + 12'd1) & {8'd0, len_q});
    wrap_off = (wrap_idx << size_q) | (addr_q[11:0] & low_mask);
    case (burst_q)
      2'd1:    next_off = addr_q[11:0] + step;
      2'd2:    next_off = wrap_off;
      default: next_off = addr_q[11:0];
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    qos_d   = qos_q;
    beats_d = beats_q;
    if (ar_pop) begin
      addr_d  = ar_head.addr;
      id_d    = ar_head.id;
      len_d   = ar_head.len;
      size_d  = (ar_head.size == 2'd3) ? 2'd2 : ar_head.size;
      burst_d = ar_head.burst;
      qos_d   = ar_head.qos;
      beats_d = ar_head.len;
    end else if (beat) begin
      addr_d  = {addr_q[31:12], next_off};
      beats_d = beats_q - 4'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      qos_q   <= '0;
      beats_q <= '0;
    end else begin
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      qos_q   <= qos_d;
      beats_q <= beats_d;
    end
  end

  assign r_push = beat;
  assign r_pop  = bus.rvalid && bus.rready;

  always_ff @(posedge aclk) begin
    if (r_push)
      r_mem[r_wr_q] <= '{data: bus.sim_rd_data, id: id_q, last: (beats_q == 4'd0),
                         resp: (burst_q == 2'd3) ? 2'b10 : 2'b00};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_q  <= '0;
      r_rd_q  <= '0;
      r_cnt_q <= '0;
    end else begin
      if (r_push) r_wr_q <= r_wr_q + 1'b1;
      if (r_pop)  r_rd_q <= r_rd_q + 1'b1;
      case ({r_push, r_pop})
        2'b10:   r_cnt_q <= r_cnt_q + 1'b1;
        2'b01:   r_cnt_q <= r_cnt_q - 1'b1;
        default: r_cnt_q <= r_cnt_q;
      endcase
    end
  end

  // Head fields are zeroed while empty so stale storage never shows on R.
  assign r_head     = r_mem[r_rd_q];
  assign bus.rvalid = (r_cnt_q != '0);
  assign bus.rdata  = bus.rvalid ? r_head.data : 32'd0;
  assign bus.rid    = bus.rvalid ? r_head.id   : 6'd0;
  assign bus.rlast  = bus.rvalid && r_head.last;
  assign bus.rresp  = bus.rvalid ? r_head.resp : 2'b00;

  assign bus.sim_rd_valid   = sim_valid;
  assign bus.sim_rd_address = addr_q;
  assign bus.sim_rid        = id_q;
  assign bus.sim_rd_size    = size_q;
  assign bus.sim_rd_qos     = qos_q;

`ifdef SAXI_GP_RD_ATTR_CHECK_EN
  always @(posedge aclk) begin
    if (aresetn && ar_push) begin
      if ((bus.arlock & 2'b11) != 2'b00) begin
        $display("%m: %0t unexpected arlock %b", $time, bus.arlock);
        $stop;
      end
      if ((bus.arcache & 4'b0011) != 4'b0011) begin
        $display("%m: %0t unexpected arcache %b", $time, bus.arcache);
        $stop;
      end
      if ((bus.arprot & 3'b010) != 3'b000) begin
        $display("%m: %0t unexpected arprot %b", $time, bus.arprot);
        $stop;
      end
    end
  end
`else
  logic attr_unused;
  assign attr_unused = ^{bus.arlock, bus.arcache, bus.arprot};
`endif

endmodule

// File: tb/tb_simul_saxi_gp_rd.sv
// tb/tb_simul_saxi_gp_rd.sv - table, hand-written and random checks of simul_saxi_gp_rd against a burst-level model
module tb_simul_saxi_gp_rd;
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  simul_saxi_gp_rd_if bus();
  simul_saxi_gp_rd dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  typedef struct packed { logic [31:0] addr; logic [5:0] id; } sim_exp_t;
  typedef struct packed { logic [31:0] data; logic [5:0] id; logic last; logic [1:0] resp; } r_exp_t;
  typedef struct packed {
    logic [31:0] addr; logic [3:0] len; logic [1:0] size; logic [1:0] burst; logic [5:0] id;
    logic [3:0][31:0] ea; logic [1:0] eresp;
  } vec_t;

  int n_checks = 0, n_fail = 0, cyc_n = 0, r_occ = 0, ar_cyc = 0;
  bit ar_acc;
  sim_exp_t sim_q[$];
  r_exp_t   r_q[$];
  logic [31:0] obs_addr[$];
  r_exp_t   obs_r[$];
  int obs_sim_cyc[$], obs_r_cyc[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a, input logic [5:0] id);
    return a ^ {id, 26'h2a55a5a};
  endfunction

  // Beat address from the AXI burst formulas, kept inside the 4KB page.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [1:0] size, input logic [1:0] burst, input int i);
    int sz, step, off, ws, b;
    sz   = (size == 2'd3) ? 2 : int'(size);
    step = 1 << sz;
    off  = int'(a[11:0]);
    if (burst == 2'd1) off = (off + i * step) % 4096;
    else if (burst == 2'd2) begin
      ws  = (int'(len) + 1) * step;
      b   = (off / ws) * ws;
      off = b + ((off - b) + i * step) % ws;
    end
    return {a[31:12], off[11:0]};
  endfunction

  task automatic monitor();
    sim_exp_t se;
    r_exp_t   re;
    ar_acc = 1'b0;
    if (!aresetn) begin
      sim_q.delete(); r_q.delete(); r_occ = 0;
      return;
    end
    if (r_occ == 8) chk("sim_stall_when_full", 32'(bus.sim_rd_valid), 32'd0);
    chk("rvalid_vs_occupancy", 32'(bus.rvalid), 32'(r_occ != 0));
    if (bus.arvalid && bus.arready) begin
      ar_acc = 1'b1;
      ar_cyc = cyc_n;
      for (int i = 0; i <= int'(bus.arlen); i++) begin
        se.addr = beat_addr(bus.araddr, bus.arlen, bus.arsize, bus.arburst, i);
        se.id   = bus.arid;
        sim_q.push_back(se);
        re.data = mem_data(se.addr, bus.arid);
        re.id   = bus.arid;
        re.last = (i == int'(bus.arlen));
        re.resp = (bus.arburst == 2'd3) ? 2'b10 : 2'b00;
        r_q.push_back(re);
      end
    end
    if (bus.sim_rd_valid && bus.sim_rd_ready) begin
      obs_addr.push_back(bus.sim_rd_address);
      obs_sim_cyc.push_back(cyc_n);
      r_occ++;
      if (sim_q.size() == 0) chk("sim_beat_unexpected", 32'd1, 32'd0);
      else begin
        se = sim_q.pop_front();
        chk("sim_rd_address", bus.sim_rd_address, se.addr);
        chk("sim_rid", 32'(bus.sim_rid), 32'(se.id));
      end
    end
    if (bus.rvalid && bus.rready) begin
      re.data = bus.rdata; re.id = bus.rid; re.last = bus.rlast; re.resp = bus.rresp;
      obs_r.push_back(re);
      obs_r_cyc.push_back(cyc_n);
      r_occ--;
      if (r_q.size() == 0) chk("r_beat_unexpected", 32'd1, 32'd0);
      else begin
        re = r_q.pop_front();
        chk("rdata", bus.rdata, re.data);
        chk("rid", 32'(bus.rid), 32'(re.id));
        chk("rlast", 32'(bus.rlast), 32'(re.last));
        chk("rresp", 32'(bus.rresp), 32'(re.resp));
      end
    end
  endtask

  task automatic cyc();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    cyc_n++;
    bus.sim_rd_data = mem_data(bus.sim_rd_address, bus.sim_rid);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_r.delete(); obs_sim_cyc.delete(); obs_r_cyc.delete();
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [3:0] len, input logic [1:0] size,
                        input logic [1:0] burst, input logic [5:0] id);
    bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arqos = 4'(id);
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] len, input logic [1:0] size,
                         input logic [1:0] burst, input logic [5:0] id);
    set_ar(a, len, size, burst, id);
    bus.arvalid = 1'b1;
    ar_acc = 1'b0;
    for (int w = 0; w < 40 && !ar_acc; w++) cyc();
    if (!ar_acc) chk("ar_accept_timeout", 32'd0, 32'd1);
    bus.arvalid = 1'b0;
  endtask

  task automatic run_until_r(input int n, input int bound);
    for (int w = 0; w < bound && obs_r.size() < n; w++) cyc();
    chk("r_beat_count", 32'(obs_r.size()), 32'(n));
  endtask

  task automatic drain();
    bus.arvalid = 1'b0; bus.rready = 1'b1; bus.sim_rd_ready = 1'b1;
    for (int w = 0; w < 600 && (sim_q.size() != 0 || r_q.size() != 0); w++) cyc();
    chk("drain_sim_left", 32'(sim_q.size()), 32'd0);
    chk("drain_r_left", 32'(r_q.size()), 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [3:0] len, input logic [1:0] size,
                              input logic [1:0] burst, input logic [5:0] id, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                              input logic [1:0] resp);
    vec_t v;
    v.addr = a; v.len = len; v.size = size; v.burst = burst; v.id = id;
    v.ea[0] = e0; v.ea[1] = e1; v.ea[2] = e2; v.ea[3] = e3; v.eresp = resp;
    return v;
  endfunction

  initial begin
    int n_acc;
    vecs[0] = mk(32'h1000_0ff8, 4'd3, 2'd2, 2'd1, 6'd7,  32'h1000_0ff8, 32'h1000_0ffc, 32'h1000_0000, 32'h1000_0004, 2'b00);
    vecs[1] = mk(32'h0000_0038, 4'd3, 2'd2, 2'd2, 6'd12, 32'h38, 32'h3c, 32'h30, 32'h34, 2'b00);
    vecs[2] = mk(32'h2000_0104, 4'd2, 2'd1, 2'd0, 6'd3,  32'h2000_0104, 32'h2000_0104, 32'h2000_0104, 32'h0, 2'b00);
    vecs[3] = mk(32'h0000_0044, 4'd1, 2'd2, 2'd3, 6'd40, 32'h44, 32'h44, 32'h0, 32'h0, 2'b10);
    vecs[4] = mk(32'h0000_0007, 4'd3, 2'd0, 2'd1, 6'd1,  32'h07, 32'h08, 32'h09, 32'h0a, 2'b00);
    vecs[5] = mk(32'h0000_0106, 4'd1, 2'd1, 2'd2, 6'd2,  32'h106, 32'h104, 32'h0, 32'h0, 2'b00);
    vecs[6] = mk(32'h0000_0010, 4'd1, 2'd3, 2'd1, 6'd63, 32'h10, 32'h14, 32'h0, 32'h0, 2'b00);
    vecs[7] = mk(32'h0000_002c, 4'd1, 2'd2, 2'd2, 6'd9,  32'h2c, 32'h28, 32'h0, 32'h0, 2'b00);

    bus.arvalid = 1'b0; bus.rready = 1'b0; bus.sim_rd_ready = 1'b0; bus.sim_rd_data = 32'd0;
    bus.arlock = 2'b00; bus.arcache = 4'b0011; bus.arprot = 3'b000;
    set_ar(32'd0, 4'd0, 2'd2, 2'd1, 6'd0);
    aresetn = 1'b0;
    repeat (3) cyc();
    aresetn = 1'b1;
    chk("reset_arready", 32'(bus.arready), 32'd1);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset_rlast", 32'(bus.rlast), 32'd0);
    chk("reset_rid", 32'(bus.rid), 32'd0);
    chk("reset_rresp", 32'(bus.rresp), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_sim_rd_valid", 32'(bus.sim_rd_valid), 32'd0);
    chk("reset_sim_rd_address", bus.sim_rd_address, 32'd0);

    bus.rready = 1'b1; bus.sim_rd_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      clear_obs();
      send_ar(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id);
      run_until_r(int'(vecs[v].len) + 1, 60);
      for (int i = 0; i <= int'(vecs[v].len); i++) begin
        if (i < obs_addr.size()) chk($sformatf("vec%0d_addr%0d", v, i), obs_addr[i], vecs[v].ea[i]);
        if (i < obs_r.size()) begin
          chk($sformatf("vec%0d_rresp%0d", v, i), 32'(obs_r[i].resp), 32'(vecs[v].eresp));
          chk($sformatf("vec%0d_rlast%0d", v, i), 32'(obs_r[i].last), 32'(i == int'(vecs[v].len)));
          chk($sformatf("vec%0d_rid%0d", v, i), 32'(obs_r[i].id), 32'(vecs[v].id));
        end
      end
      if (v == 0 && obs_r_cyc.size() > 0) chk("first_rvalid_latency", 32'(obs_r_cyc[0] - ar_cyc), 32'd3);
      repeat (2) cyc();
    end

    clear_obs();
    send_ar(32'h200, 4'd1, 2'd2, 2'd1, 6'd5);
    send_ar(32'h300, 4'd1, 2'd2, 2'd1, 6'd9);
    run_until_r(4, 40);
    if (obs_sim_cyc.size() == 4) chk("b2b_no_bubble", 32'(obs_sim_cyc[3] - obs_sim_cyc[0]), 32'd3);
    if (obs_r.size() == 4) begin
      chk("b2b_rid_pattern", 32'({obs_r[0].id, obs_r[1].id, obs_r[2].id, obs_r[3].id}), 32'({6'd5, 6'd5, 6'd9, 6'd9}));
      chk("b2b_rlast_pattern", 32'({obs_r[0].last, obs_r[1].last, obs_r[2].last, obs_r[3].last}), 32'b0101);
    end

    clear_obs();
    bus.rready = 1'b0; bus.sim_rd_ready = 1'b1;
    n_acc = 0;
    set_ar(32'h400, 4'd0, 2'd2, 2'd1, 6'd0);
    bus.arvalid = 1'b1;
    for (int w = 0; w < 80; w++) begin
      cyc();
      if (ar_acc) begin
        n_acc++;
        set_ar(32'h400 + 32'(4 * n_acc), 4'd0, 2'd2, 2'd1, 6'(n_acc));
      end
      if (!bus.arready) break;
    end
    bus.arvalid = 1'b0;
    chk("bp_ars_accepted", 32'(n_acc), 32'd17);
    repeat (4) cyc();
    chk("bp_sim_rd_valid", 32'(bus.sim_rd_valid), 32'd0);
    chk("bp_arready_low", 32'(bus.arready), 32'd0);
    chk("bp_r_fifo_beats", 32'(obs_addr.size()), 32'd8);
    drain();
    chk("bp_all_returned", 32'(obs_r.size()), 32'd17);

    clear_obs();
    bus.rready = 1'b0;
    send_ar(32'h500, 4'd3, 2'd2, 2'd1, 6'd20);
    send_ar(32'h600, 4'd3, 2'd2, 2'd1, 6'd21);
    send_ar(32'h700, 4'd3, 2'd2, 2'd1, 6'd22);
    repeat (2) cyc();
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    chk("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_mid_sim_rd_valid", 32'(bus.sim_rd_valid), 32'd0);
    chk("rst_mid_arready", 32'(bus.arready), 32'd1);
    clear_obs();
    bus.rready = 1'b1;
    send_ar(32'h800, 4'd1, 2'd2, 2'd1, 6'd33);
    run_until_r(2, 40);
    repeat (10) cyc();
    chk("rst_mid_no_stale", 32'(obs_r.size()), 32'd2);

    for (int c = 0; c < 1500; c++) begin
      if (ar_acc || !bus.arvalid) begin
        bus.arvalid = ($urandom_range(0, 2) == 0);
        if (bus.arvalid) begin
          logic [1:0] b;
          logic [3:0] l;
          b = 2'($urandom_range(0, 3));
          l = 4'($urandom_range(0, 15));
          if (b == 2'd2) case ($urandom_range(0, 4))
            0: l = 4'd0; 1: l = 4'd1; 2: l = 4'd3; 3: l = 4'd7; default: l = 4'd15;
          endcase
          set_ar($urandom, l, 2'($urandom_range(0, 3)), b, 6'($urandom));
        end
      end
      bus.rready = ($urandom_range(0, 3) != 0);
      bus.sim_rd_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    if (bus.arvalid && !ar_acc) begin
      for (int w = 0; w < 200 && !ar_acc; w++) begin
        bus.rready = 1'b1; bus.sim_rd_ready = 1'b1;
        cyc();
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
